ecc_op_ctrl: RTL and testbench
==============================

# ecc_op_ctrl

Operation sequencer for the ECC encoder/decoder. Accepts an opcode from the APB register bank's CTRL write and drives the encoder and decoder through start/done handshakes. Full-channel mode chains encode, noise injection and decode. Returns `data_out`, `num_of_errors` and a one-cycle `operation_done` pulse to the top level.

## Interface
- `DATA_WIDTH`, 32, width of the data/codeword path to the ENC and DEC units
- `TIMEOUT_CYCLES`, 64, maximum cycles a unit may take to return done before the operation is aborted (≥2)

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `ctrl_wr`  in  1  one-cycle pulse: register bank wrote CTRL
- `ctrl_op`  in  2  opcode: 0 encode, 1 decode, 2 full channel, 3 illegal
- `data_in`  in  DATA_WIDTH  DATA_IN register contents
- `noise`  in  DATA_WIDTH  NOISE register contents (XOR mask)
- `enc_start`  out  1  one-cycle start pulse to the encoder
- `enc_data`  out  DATA_WIDTH  encoder operand, held stable while ENC is active
- `enc_done`  in  1  encoder result valid (one cycle)
- `enc_result`  in  DATA_WIDTH  encoder codeword
- `dec_start`  out  1  one-cycle start pulse to the decoder
- `dec_data`  out  DATA_WIDTH  decoder operand, held stable while DEC is active
- `dec_done`  in  1  decoder result valid (one cycle)
- `dec_result`  in  DATA_WIDTH  decoded data
- `dec_errors`  in  2  decoder status: 00 none, 01 corrected, 10 detected
- `data_out`  out  DATA_WIDTH  last operation result
- `operation_done`  out  1  one-cycle completion pulse
- `num_of_errors`  out  2  status of last operation; 11 means timeout
- `busy`  out  1  high when state ≠ IDLE

## Operation
- **FSM states:** IDLE, ENC, DEC. A `full` flag is latched at acceptance.
- **IDLE:**
  - A `ctrl_wr` with `ctrl_op` 0, 1 or 2 is accepted.
  - On acceptance, latch `data_in` into the operand register, latch `noise`, and set `full` = (`ctrl_op` == 2).
  - Opcode 0 or 2 → ENC. Opcode 1 → DEC. Opcode 3 → ignored, stay IDLE, no outputs change.
- **Entry into ENC/DEC:** `enc_start`/`dec_start` is asserted for exactly the first cycle in the state, and the phase timeout counter is cleared.
- **Done sampling:** `enc_done`/`dec_done` is sampled only in cycles after the start cycle. Done in the start cycle is ignored.
- **ENC, done, `full` = 0:**
  - `data_out` ← `enc_result`, `num_of_errors` ← 00.
  - Pulse `operation_done`, go to IDLE.
- **ENC, done, `full` = 1:** go to DEC with `dec_data` ← `enc_result` ^ `noise_latched`. No `operation_done`.
- **DEC, done:**
  - `data_out` ← `dec_result`, `num_of_errors` ← `dec_errors`.
  - Pulse `operation_done`, go to IDLE.
- **Timeout:** the counter increments each non-start cycle in ENC/DEC. When it reaches `TIMEOUT_CYCLES` without done:
  - `data_out` ← 0, `num_of_errors` ← 11.
  - Pulse `operation_done`, go to IDLE.
- **`ctrl_wr` while busy:** dropped, with no queueing and no effect on the running operation.
- **Register changes mid-operation:** changes to `data_in`/`noise` after acceptance have no effect.
- **Output stability:** `data_out` and `num_of_errors` hold until the next completion. `enc_data`/`dec_data` hold until the next acceptance.

## Timing
- **Reset values:** IDLE, `full` = 0, counter 0. All outputs 0: `enc_start`, `dec_start`, `enc_data`, `dec_data`, `data_out`, `operation_done`, `num_of_errors`, `busy`.
- **Reset mid-operation:** aborts immediately, with no `operation_done` pulse and no further start pulses. Late done inputs are ignored in IDLE.
- **Start latency:** `ctrl_wr` accepted at cycle T → `busy` and the start pulse at T+1.
- **Completion latency:** done sampled at cycle D → `operation_done`, `data_out` and `num_of_errors` updated at D+1. `busy` is low at D+1.
- **Back-to-back:** a `ctrl_wr` at D+1, the same cycle as `operation_done`, is accepted.
- **Full-channel latency:** `enc_done` at E → `dec_start` at E+1. Minimum end-to-end latency is T → T+5, with both units answering one cycle after start.
- **Timeout:** with no done, `operation_done` occurs `TIMEOUT_CYCLES` + 1 cycles after the start pulse, per phase.
- **Registering:** all outputs are registered. No combinational path from inputs to outputs.

## Test plan
- **Encode:**
  - Stimulus: `ctrl_wr`, op 0, `data_in` = 0x0000_00A5. Encoder returns `enc_result` = 0x1234_56A5 two cycles after start.
  - Required: `enc_start` at T+1, `operation_done` at T+4, `data_out` = 0x1234_56A5, `num_of_errors` = 00.
- **Decode:**
  - Stimulus: op 1, `data_in` = 0xDEAD_BEEF. Decoder returns 0x0000_00EF, errors 01.
  - Required: `dec_data` = 0xDEAD_BEEF, `enc_start` never asserted, `num_of_errors` = 01.
- **Full channel:**
  - Stimulus: op 2, `noise` = 0x0000_0001, `enc_result` = 0x0000_00F0.
  - Required: `dec_start` one cycle after `enc_done`, `dec_data` = 0x0000_00F1. `operation_done` exactly once, after `dec_done`.
- **Busy / illegal:**
  - Stimulus: `ctrl_wr` op 1 while ENC is active, plus op 3 in IDLE.
  - Required: both ignored. The single completion reflects the original op 0.
- **Timeout:**
  - Stimulus: op 0 with `enc_done` never asserted, `TIMEOUT_CYCLES` = 64.
  - Required: `operation_done` at start+65, `num_of_errors` = 11, `data_out` = 0.
- **Reset mid-op / back-to-back:**
  - Stimulus: `rst` in DEC, then `dec_done` arrives.
  - Required: no `operation_done`, all outputs 0.
  - Follow-up: a `ctrl_wr` in the `operation_done` cycle is accepted, with `busy` high next cycle.

Source files
------------

// File: rtl/ecc_op_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : ecc_op_ctrl                                                   |
// | Purpose  : Sequences ENC, DEC and full-channel ECC operations through   |
// |            start/done handshakes, with a per-phase timeout.             |
// | Revision : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module ecc_op_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_wr,
    input  logic [1:0]            ctrl_op,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] noise,
    output logic                  enc_start,
    output logic [DATA_WIDTH-1:0] enc_data,
    input  logic                  enc_done,
    input  logic [DATA_WIDTH-1:0] enc_result,
    output logic                  dec_start,
    output logic [DATA_WIDTH-1:0] dec_data,
    input  logic                  dec_done,
    input  logic [DATA_WIDTH-1:0] dec_result,
    input  logic [1:0]            dec_errors,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  operation_done,
    output logic [1:0]            num_of_errors,
    output logic                  busy
);

    localparam int            c_CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ENC  = 2'd1;
    localparam logic [1:0] c_DEC  = 2'd2;

    localparam logic [1:0] c_OP_ENC  = 2'd1 - 2'd1;
    localparam logic [1:0] c_OP_DEC  = 2'd1;
    localparam logic [1:0] c_OP_FULL = 2'd2;
    localparam logic [1:0] c_OP_ILL  = 2'd3;
    localparam logic [1:0] c_ERR_TO  = 2'b11;

    logic [1:0]            r_state;
    logic                  r_full;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_noise;
    logic                  r_enc_start;
    logic                  r_dec_start;
    logic [DATA_WIDTH-1:0] r_enc_data;
    logic [DATA_WIDTH-1:0] r_dec_data;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_op_done;
    logic [1:0]            r_errors;
    logic                  r_busy;

    // The start pulse doubles as the "first cycle in phase" marker, so done
    // arriving together with start is never sampled.
    logic w_enc_sample;
    logic w_dec_sample;
    assign w_enc_sample = (r_state == c_ENC) && !r_enc_start;
    assign w_dec_sample = (r_state == c_DEC) && !r_dec_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_full      <= 1'b0;
            r_cnt       <= '0;
            r_noise     <= '0;
            r_enc_start <= 1'b0;
            r_dec_start <= 1'b0;
            r_enc_data  <= '0;
            r_dec_data  <= '0;
            r_data_out  <= '0;
            r_op_done   <= 1'b0;
            r_errors    <= 2'b00;
            r_busy      <= 1'b0;
        end else begin
            r_enc_start <= 1'b0;
            r_dec_start <= 1'b0;
            r_op_done   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (ctrl_wr && (ctrl_op != c_OP_ILL)) begin
                        r_noise <= noise;
                        r_full  <= (ctrl_op == c_OP_FULL);
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        if (ctrl_op == c_OP_DEC) begin
                            r_state     <= c_DEC;
                            r_dec_start <= 1'b1;
                            r_dec_data  <= data_in;
                        end else begin
                            r_state     <= c_ENC;
                            r_enc_start <= 1'b1;
                            r_enc_data  <= data_in;
                        end
                    end
                end
                c_ENC: begin
                    if (w_enc_sample) begin
                        if (enc_done) begin
                            if (r_full) begin
                                r_state     <= c_DEC;
                                r_dec_start <= 1'b1;
                                r_dec_data  <= enc_result ^ r_noise;
                                r_cnt       <= '0;
                            end else begin
                                r_state    <= c_IDLE;
                                r_busy     <= 1'b0;
                                r_op_done  <= 1'b1;
                                r_data_out <= enc_result;
                                r_errors   <= 2'b00;
                            end
                        end else if (r_cnt == c_TO_LAST) begin
                            r_state    <= c_IDLE;
                            r_busy     <= 1'b0;
                            r_op_done  <= 1'b1;
                            r_data_out <= '0;
                            r_errors   <= c_ERR_TO;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                c_DEC: begin
                    if (w_dec_sample) begin
                        if (dec_done) begin
                            r_state    <= c_IDLE;
                            r_busy     <= 1'b0;
                            r_op_done  <= 1'b1;
                            r_data_out <= dec_result;
                            r_errors   <= dec_errors;
                        end else if (r_cnt == c_TO_LAST) begin
                            r_state    <= c_IDLE;
                            r_busy     <= 1'b0;
                            r_op_done  <= 1'b1;
                            r_data_out <= '0;
                            r_errors   <= c_ERR_TO;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign enc_start      = r_enc_start;
    assign dec_start      = r_dec_start;
    assign enc_data       = r_enc_data;
    assign dec_data       = r_dec_data;
    assign data_out       = r_data_out;
    assign operation_done = r_op_done;
    assign num_of_errors  = r_errors;
    assign busy           = r_busy;

    // Encode opcode value is implied by the else-branch above.
    logic w_unused;
    assign w_unused = &{1'b0, c_OP_ENC};

endmodule

`default_nettype wire

// File: tb/tb_ecc_op_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_ecc_op_ctrl                                                |
// | Purpose  : Directed, table-driven bench for ecc_op_ctrl.                 |
// | Revision : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_ecc_op_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_wr;
    logic [1:0]  ctrl_op;
    logic [31:0] data_in, noise;
    logic        enc_start, dec_start;
    logic [31:0] enc_data, dec_data;
    logic        enc_done, dec_done;
    logic [31:0] enc_result, dec_result;
    logic [1:0]  dec_errors;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ecc_op_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .ctrl_wr(ctrl_wr), .ctrl_op(ctrl_op),
        .data_in(data_in), .noise(noise),
        .enc_start(enc_start), .enc_data(enc_data), .enc_done(enc_done),
        .enc_result(enc_result),
        .dec_start(dec_start), .dec_data(dec_data), .dec_done(dec_done),
        .dec_result(dec_result), .dec_errors(dec_errors),
        .data_out(data_out), .operation_done(operation_done),
        .num_of_errors(num_of_errors), .busy(busy)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] din, nse, enc_res, dec_res;
        logic [1:0]  dec_err;
        int          enc_lat, dec_lat;  // cycles after start; 0 = never answers
        bit          early, busy_wr;
        int          x_enc_s, x_dec_s, x_done;  // 0 = no start expected
        logic [31:0] x_enc_data, x_dec_data, x_out;
        logic [1:0]  x_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int enc_s = 0, dec_s = 0, done_k = 0, done_cnt = 0, enc_cnt = 0, dec_cnt = 0;
        logic [31:0] enc_d = '0, dec_d = '0;
        ctrl_wr = 1'b1; ctrl_op = v.op; data_in = v.din; noise = v.nse;
        for (int k = 1; k <= 150; k++) begin
            tick();
            ctrl_wr = 1'b0;
            data_in = ~v.din;
            noise   = 32'h5A5A_0000;
            if (v.busy_wr && k == 2) begin
                ctrl_wr = 1'b1;
                ctrl_op = 2'd1;
            end
            if (k == 1) chk($sformatf("v%0d busy_after_accept", idx), busy, 1);
            if (enc_start) begin
                enc_cnt++;
                if (enc_s == 0) begin enc_s = k; enc_d = enc_data; end
            end
            if (dec_start) begin
                dec_cnt++;
                if (dec_s == 0) begin dec_s = k; dec_d = dec_data; end
            end
            if (operation_done) begin
                done_cnt++;
                if (done_k == 0) begin
                    done_k = k;
                    chk($sformatf("v%0d data_out", idx), data_out, v.x_out);
                    chk($sformatf("v%0d num_of_errors", idx), num_of_errors, v.x_err);
                    chk($sformatf("v%0d busy_at_done", idx), busy, 0);
                end
            end
            enc_done   = (enc_s > 0) && ((v.enc_lat > 0 && k == enc_s + v.enc_lat) ||
                                         (v.early && k == enc_s));
            enc_result = (enc_done && k != enc_s) ? v.enc_res : 32'hBAD0_0BAD;
            dec_done   = (dec_s > 0) && ((v.dec_lat > 0 && k == dec_s + v.dec_lat) ||
                                         (v.early && k == dec_s));
            dec_result = (dec_done && k != dec_s) ? v.dec_res : 32'hBAD0_0BAD;
            dec_errors = (dec_done && k != dec_s) ? v.dec_err : 2'b11;
            if (done_k > 0 && k >= done_k + 3) break;
        end
        enc_done = 1'b0; dec_done = 1'b0; ctrl_wr = 1'b0;
        chk($sformatf("v%0d done_cycle", idx), done_k, v.x_done);
        chk($sformatf("v%0d done_count", idx), done_cnt, 1);
        chk($sformatf("v%0d enc_start_count", idx), enc_cnt, (v.x_enc_s > 0) ? 1 : 0);
        chk($sformatf("v%0d dec_start_count", idx), dec_cnt, (v.x_dec_s > 0) ? 1 : 0);
        chk($sformatf("v%0d enc_start_cycle", idx), enc_s, v.x_enc_s);
        chk($sformatf("v%0d dec_start_cycle", idx), dec_s, v.x_dec_s);
        if (v.x_enc_s > 0) chk($sformatf("v%0d enc_data", idx), enc_d, v.x_enc_data);
        if (v.x_dec_s > 0) chk($sformatf("v%0d dec_data", idx), dec_d, v.x_dec_data);
        chk($sformatf("v%0d data_out_hold", idx), data_out, v.x_out);
    endtask

    initial begin
        logic        bad;
        logic [31:0] prev_out;

        //           op    din            noise          enc_res        dec_res        err  el  dl  ea bw  xe xd xdone x_enc_data     x_dec_data     x_out          x_err
        vecs[0] = '{2'd0, 32'h0000_00A5, 32'h0,         32'h1234_56A5, 32'h0,         2'd0, 2, 0, 0, 1, 1, 0, 4,  32'h0000_00A5, 32'h0,         32'h1234_56A5, 2'd0};
        vecs[1] = '{2'd1, 32'hDEAD_BEEF, 32'h0,         32'h0,         32'h0000_00EF, 2'd1, 0, 2, 0, 0, 0, 1, 4,  32'h0,         32'hDEAD_BEEF, 32'h0000_00EF, 2'd1};
        vecs[2] = '{2'd2, 32'h0000_0011, 32'h0000_0001, 32'h0000_00F0, 32'h0000_00F0, 2'd1, 1, 1, 0, 0, 1, 3, 5,  32'h0000_0011, 32'h0000_00F1, 32'h0000_00F0, 2'd1};
        vecs[3] = '{2'd2, 32'h0000_00CD, 32'h0000_0300, 32'h00AB_CD00, 32'h0000_CD00, 2'd2, 3, 2, 1, 1, 1, 5, 8,  32'h0000_00CD, 32'h00AB_CE00, 32'h0000_CD00, 2'd2};
        vecs[4] = '{2'd0, 32'h0F0F_0F0F, 32'h0,         32'h0,         32'h0,         2'd0, 0, 0, 0, 1, 1, 0, 66, 32'h0F0F_0F0F, 32'h0,         32'h0,         2'd3};
        vecs[5] = '{2'd2, 32'h2222_2222, 32'h8000_0000, 32'h1111_1111, 32'h0,         2'd0, 1, 0, 0, 0, 1, 3, 68, 32'h2222_2222, 32'h9111_1111, 32'h0,         2'd3};
        vecs[6] = '{2'd1, 32'h1357_9BDF, 32'h0,         32'h0,         32'h0000_0042, 2'd0, 0, 5, 1, 0, 0, 1, 7,  32'h0,         32'h1357_9BDF, 32'h0000_0042, 2'd0};

        rst = 1'b1; ctrl_wr = 1'b0; ctrl_op = 2'd0; data_in = '0; noise = '0;
        enc_done = 1'b0; dec_done = 1'b0; enc_result = '0; dec_result = '0; dec_errors = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {enc_start, dec_start, enc_data, dec_data, data_out, operation_done, num_of_errors, busy}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
            tick();
        end

        // Illegal opcode in IDLE: nothing may move.
        prev_out = data_out;
        ctrl_wr = 1'b1; ctrl_op = 2'd3; data_in = 32'hFFFF_FFFF;
        bad = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            ctrl_wr = 1'b0;
            if (busy || enc_start || dec_start || operation_done || data_out !== prev_out) bad = 1'b1;
        end
        chk("illegal_op_ignored", bad, 0);

        // Reset while DEC is active, then a late dec_done.
        ctrl_wr = 1'b1; ctrl_op = 2'd1; data_in = 32'hCAFE_F00D;
        tick();
        ctrl_wr = 1'b0;
        chk("rst_mid_dec_start", dec_start, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_outputs",
            {enc_start, dec_start, enc_data, dec_data, data_out, operation_done, num_of_errors, busy}, 0);
        dec_done = 1'b1; dec_result = 32'h0000_0077; dec_errors = 2'd1;
        bad = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            dec_done = 1'b0;
            if ({enc_start, dec_start, enc_data, dec_data, data_out, operation_done, num_of_errors, busy} != 0)
                bad = 1'b1;
        end
        chk("rst_late_done_ignored", bad, 0);

        // Back-to-back: new write in the operation_done cycle.
        ctrl_wr = 1'b1; ctrl_op = 2'd0; data_in = 32'h0000_0077;
        tick();
        ctrl_wr = 1'b0;
        chk("b2b_enc_start", enc_start, 1);
        tick();
        enc_done = 1'b1; enc_result = 32'h0000_0777;
        tick();
        enc_done = 1'b0;
        chk("b2b_first_done", operation_done, 1);
        chk("b2b_first_out", data_out, 32'h0000_0777);
        ctrl_wr = 1'b1; ctrl_op = 2'd1; data_in = 32'h0000_0055;
        tick();
        ctrl_wr = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_dec_start", dec_start, 1);
        chk("b2b_dec_data", dec_data, 32'h0000_0055);
        tick();
        dec_done = 1'b1; dec_result = 32'h0000_0005; dec_errors = 2'd2;
        tick();
        dec_done = 1'b0;
        chk("b2b_second_done", operation_done, 1);
        chk("b2b_second_out", {num_of_errors, data_out}, {2'd2, 32'h0000_0005});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
